// File: rtl/mips_ctrl_pkg.sv
// Shared codes and state encodings for the multicycle MIPS controller, datapath and ALU.
// The TRAP state exists only when MIPS_CTRL_ILLEGAL_TRAP_EN is defined.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [4:0] ALU_ADD = 5'b00010;
  localparam logic [4:0] ALU_SUB = 5'b00110;
  localparam logic [4:0] ALU_AND = 5'b00000;
  localparam logic [4:0] ALU_OR  = 5'b00001;
  localparam logic [4:0] ALU_SLT = 5'b00111;

  localparam logic [1:0] PCSRC_ALU = 2'b00;
  localparam logic [1:0] PCSRC_TGT = 2'b01;
  localparam logic [1:0] PCSRC_JMP = 2'b10;

  localparam logic [1:0] SRCB_B    = 2'b00;
  localparam logic [1:0] SRCB_4    = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_IMM4 = 2'b11;

  localparam logic [3:0] S_FETCH  = 4'd0;
  localparam logic [3:0] S_INC    = 4'd1;
  localparam logic [3:0] S_DECODE = 4'd2;
  localparam logic [3:0] S_EXEC   = 4'd3;
  localparam logic [3:0] S_RWB    = 4'd4;
  localparam logic [3:0] S_MEMADR = 4'd5;
  localparam logic [3:0] S_MEMRD  = 4'd6;
  localparam logic [3:0] S_MEMWR  = 4'd7;
  localparam logic [3:0] S_MEMWB  = 4'd8;
  localparam logic [3:0] S_BR_TGT = 4'd9;
  localparam logic [3:0] S_BR_CMP = 4'd10;
  localparam logic [3:0] S_ADDIEX = 4'd11;
  localparam logic [3:0] S_ADDIWB = 4'd12;
  localparam logic [3:0] S_JUMP   = 4'd13;
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
  localparam logic [3:0] S_TRAP   = 4'd14;
`endif

endpackage

// File: rtl/mips_controller_alu_decoder.sv
// Combinational funct-to-ALUControl map for R-type instructions; flags unknown funct codes.
module alu_decoder
  import mips_ctrl_pkg::*;
(
  input  logic [5:0] i_funct,
  output logic [4:0] o_alu_ctrl,
  output logic       o_illegal
);

  always_comb begin
    o_alu_ctrl = ALU_ADD;
    o_illegal  = 1'b0;
    case (i_funct)
      FN_ADD:  o_alu_ctrl = ALU_ADD;
      FN_SUB:  o_alu_ctrl = ALU_SUB;
      FN_AND:  o_alu_ctrl = ALU_AND;
      FN_OR:   o_alu_ctrl = ALU_OR;
      FN_SLT:  o_alu_ctrl = ALU_SLT;
      default: o_illegal  = 1'b1;
    endcase
  end

endmodule

// File: rtl/mips_controller.sv
// Moore-style multicycle MIPS control FSM with a memory-latency counter.
// Optional macro MIPS_CTRL_ILLEGAL_TRAP_EN: unknown op/funct locks into TRAP instead of acting as a NOP.
module mips_controller
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned MEM_LAT = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       memRead,
  output logic       memWrite,
  output logic       IorD,
  output logic       IRWrite,
  output logic       pcWrite,
  output logic       pcWriteCond,
  output logic [1:0] PCSrc,
  output logic       targetWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [4:0] ALUControl,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       illegalInsn
);

  localparam logic [3:0] LAT_LAST = 4'(MEM_LAT - 1);
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
  localparam logic [3:0] S_ILLEGAL_DST = S_TRAP;
`else
  localparam logic [3:0] S_ILLEGAL_DST = S_FETCH;
`endif

  logic [3:0] r_state;
  logic [3:0] r_cnt;
  logic [3:0] w_next;
  logic       w_lat_done;
  logic       w_counting;
  logic [4:0] w_funct_alu;
  logic       w_funct_bad;
  logic       w_irwrite, w_pcwrite, w_pcwritecond, w_targetwrite, w_memwrite, w_regwrite;
  logic       w_unused_zero;

  alu_decoder u_alu_decoder (
    .i_funct    (funct),
    .o_alu_ctrl (w_funct_alu),
    .o_illegal  (w_funct_bad)
  );

  // Branch resolution happens in the datapath, which gates pcWriteCond with zero.
  assign w_unused_zero = zero & (r_state == S_BR_CMP);

  assign w_counting = (r_state == S_FETCH) || (r_state == S_MEMRD);
  assign w_lat_done = (r_cnt == LAT_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_FETCH;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= (w_counting && !w_lat_done) ? r_cnt + 4'd1 : '0;
    end
  end

  always_comb begin
    w_next = S_FETCH;
    case (r_state)
      S_FETCH:  w_next = w_lat_done ? S_INC : S_FETCH;
      S_INC:    w_next = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_RTYPE:     w_next = S_EXEC;
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_BEQ:       w_next = S_BR_TGT;
          OP_ADDI:      w_next = S_ADDIEX;
          OP_J:         w_next = S_JUMP;
          default:      w_next = S_ILLEGAL_DST;
        endcase
      end
      S_EXEC:   w_next = w_funct_bad ? S_ILLEGAL_DST : S_RWB;
      S_MEMADR: w_next = (op == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  w_next = w_lat_done ? S_MEMWB : S_MEMRD;
      S_BR_TGT: w_next = S_BR_CMP;
      S_ADDIEX: w_next = S_ADDIWB;
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
      S_TRAP:   w_next = S_TRAP;
`endif
      default:  w_next = S_FETCH;
    endcase
  end

  always_comb begin
    memRead       = 1'b0;
    IorD          = 1'b0;
    PCSrc         = PCSRC_ALU;
    ALUSrcA       = 1'b0;
    ALUSrcB       = SRCB_B;
    ALUControl    = ALU_ADD;
    RegDst        = 1'b0;
    MemtoReg      = 1'b0;
    w_irwrite     = 1'b0;
    w_pcwrite     = 1'b0;
    w_pcwritecond = 1'b0;
    w_targetwrite = 1'b0;
    w_memwrite    = 1'b0;
    w_regwrite    = 1'b0;
    case (r_state)
      S_FETCH: begin
        memRead   = 1'b1;
        ALUSrcB   = SRCB_4;
        w_irwrite = w_lat_done;
      end
      S_INC:    w_pcwrite = 1'b1;
      S_DECODE: ALUSrcB = SRCB_IMM4;
      S_EXEC: begin
        ALUSrcA    = 1'b1;
        ALUControl = w_funct_alu;
      end
      S_RWB: begin
        RegDst     = 1'b1;
        w_regwrite = 1'b1;
      end
      S_MEMADR, S_ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
      end
      S_MEMRD: begin
        memRead = 1'b1;
        IorD    = 1'b1;
      end
      S_MEMWB: begin
        MemtoReg   = 1'b1;
        w_regwrite = 1'b1;
      end
      S_MEMWR: begin
        w_memwrite = 1'b1;
        IorD       = 1'b1;
      end
      S_BR_TGT: begin
        w_targetwrite = 1'b1;
        ALUSrcA       = 1'b1;
        ALUControl    = ALU_SUB;
      end
      S_BR_CMP: begin
        w_pcwritecond = 1'b1;
        PCSrc         = PCSRC_TGT;
      end
      S_ADDIWB: w_regwrite = 1'b1;
      S_JUMP: begin
        w_pcwrite = 1'b1;
        PCSrc     = PCSRC_JMP;
      end
      default: ;
    endcase
  end

  // Write enables are also masked directly by reset so an abort is immediate.
  assign IRWrite     = w_irwrite     & reset;
  assign pcWrite     = w_pcwrite     & reset;
  assign pcWriteCond = w_pcwritecond & reset;
  assign targetWrite = w_targetwrite & reset;
  assign memWrite    = w_memwrite    & reset;
  assign RegWrite    = w_regwrite    & reset;

`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
  assign illegalInsn = (r_state == S_TRAP);
`else
  assign illegalInsn = 1'b0;
`endif

endmodule

// File: tb/tb_mips_controller.sv
// Directed bench for mips_controller: MEM_LAT=1 and MEM_LAT=3 instances, per-cycle output vectors.
module tb_mips_controller;

  // {memRead,memWrite,IorD,IRWrite,pcWrite,pcWriteCond,PCSrc,targetWrite,ALUSrcA,ALUSrcB,ALUControl,RegDst,MemtoReg,RegWrite,illegalInsn}
  localparam logic [20:0] E_FETCH_IR = {1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,2'b00,1'b0,1'b0,2'b01,5'b00010,1'b0,1'b0,1'b0,1'b0};
  localparam logic [20:0] E_FETCH_NO = {1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,1'b0,2'b01,5'b00010,1'b0,1'b0,1'b0,1'b0};
  localparam logic [20:0] E_INC      = {1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,2'b00,1'b0,1'b0,2'b00,5'b00010,1'b0,1'b0,1'b0,1'b0};
  localparam logic [20:0] E_DECODE   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,1'b0,2'b11,5'b00010,1'b0,1'b0,1'b0,1'b0};
  localparam logic [20:0] E_EXEC_ADD = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,1'b1,2'b00,5'b00010,1'b0,1'b0,1'b0,1'b0};
  localparam logic [20:0] E_RWB      = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,1'b0,2'b00,5'b00010,1'b1,1'b0,1'b1,1'b0};
  localparam logic [20:0] E_MEMADR   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,1'b1,2'b10,5'b00010,1'b0,1'b0,1'b0,1'b0};
  localparam logic [20:0] E_MEMRD    = {1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,2'b00,1'b0,1'b0,2'b00,5'b00010,1'b0,1'b0,1'b0,1'b0};
  localparam logic [20:0] E_MEMWB    = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,1'b0,2'b00,5'b00010,1'b0,1'b1,1'b1,1'b0};
  localparam logic [20:0] E_MEMWR    = {1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,2'b00,1'b0,1'b0,2'b00,5'b00010,1'b0,1'b0,1'b0,1'b0};
  localparam logic [20:0] E_BRTGT    = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b1,1'b1,2'b00,5'b00110,1'b0,1'b0,1'b0,1'b0};
  localparam logic [20:0] E_BRCMP    = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b01,1'b0,1'b0,2'b00,5'b00010,1'b0,1'b0,1'b0,1'b0};
  localparam logic [20:0] E_ADDIWB   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,1'b0,2'b00,5'b00010,1'b0,1'b0,1'b1,1'b0};
  localparam logic [20:0] E_JUMP     = {1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,2'b10,1'b0,1'b0,2'b00,5'b00010,1'b0,1'b0,1'b0,1'b0};
  localparam logic [20:0] E_TRAP     = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,1'b0,2'b00,5'b00010,1'b0,1'b0,1'b0,1'b1};

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] op = '0;
  logic [5:0] funct = '0;
  logic       zero = 1'b0;

  logic       mr1, mw1, iod1, irw1, pcw1, pcc1, tw1, sa1, rd1, m2r1, rw1, ill1;
  logic [1:0] pcs1, sb1;
  logic [4:0] alu1;
  logic       mr3, mw3, iod3, irw3, pcw3, pcc3, tw3, sa3, rd3, m2r3, rw3, ill3;
  logic [1:0] pcs3, sb3;
  logic [4:0] alu3;
  logic [20:0] w_o1, w_o3;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mips_controller #(.MEM_LAT(1)) u_dut1 (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
    .memRead(mr1), .memWrite(mw1), .IorD(iod1), .IRWrite(irw1), .pcWrite(pcw1),
    .pcWriteCond(pcc1), .PCSrc(pcs1), .targetWrite(tw1), .ALUSrcA(sa1), .ALUSrcB(sb1),
    .ALUControl(alu1), .RegDst(rd1), .MemtoReg(m2r1), .RegWrite(rw1), .illegalInsn(ill1)
  );

  mips_controller #(.MEM_LAT(3)) u_dut3 (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
    .memRead(mr3), .memWrite(mw3), .IorD(iod3), .IRWrite(irw3), .pcWrite(pcw3),
    .pcWriteCond(pcc3), .PCSrc(pcs3), .targetWrite(tw3), .ALUSrcA(sa3), .ALUSrcB(sb3),
    .ALUControl(alu3), .RegDst(rd3), .MemtoReg(m2r3), .RegWrite(rw3), .illegalInsn(ill3)
  );

  assign w_o1 = {mr1, mw1, iod1, irw1, pcw1, pcc1, pcs1, tw1, sa1, sb1, alu1, rd1, m2r1, rw1, ill1};
  assign w_o3 = {mr3, mw3, iod3, irw3, pcw3, pcc3, pcs3, tw3, sa3, sb3, alu3, rd3, m2r3, rw3, ill3};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves both instances in FETCH cycle 1, sampled between edges.
  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    #2;
    reset = 1'b0;
    #2;
    checks++;
    if (w_o1 !== E_FETCH_NO) begin errors++; $display("FAIL reset_hold_lat1 got=%h exp=%h", w_o1, E_FETCH_NO); end
    checks++;
    if (w_o3 !== E_FETCH_NO) begin errors++; $display("FAIL reset_hold_lat3 got=%h exp=%h", w_o3, E_FETCH_NO); end
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    checks++;
    if (w_o1 !== E_FETCH_IR) begin errors++; $display("FAIL reset_release_lat1 got=%h exp=%h", w_o1, E_FETCH_IR); end
    checks++;
    if (w_o3 !== E_FETCH_NO) begin errors++; $display("FAIL reset_release_lat3 got=%h exp=%h", w_o3, E_FETCH_NO); end
  endtask

  task automatic test_rtype();
    logic [20:0] exp;
    op = 6'b000000; funct = 6'b100000;
    pulse_reset();
    for (int c = 1; c <= 6; c++) begin
      case (c)
        1: exp = E_FETCH_IR; 2: exp = E_INC; 3: exp = E_DECODE;
        4: exp = E_EXEC_ADD; 5: exp = E_RWB; default: exp = E_FETCH_IR;
      endcase
      checks++;
      if (w_o1 !== exp) begin errors++; $display("FAIL rtype_add cyc%0d got=%h exp=%h", c, w_o1, exp); end
      tick();
    end
  endtask

  task automatic test_alu_functs();
    logic [20:0] exp;
    for (int i = 0; i < 4; i++) begin
      exp = E_EXEC_ADD;
      case (i)
        0: begin funct = 6'b100010; exp[8:4] = 5'b00110; end
        1: begin funct = 6'b100100; exp[8:4] = 5'b00000; end
        2: begin funct = 6'b100101; exp[8:4] = 5'b00001; end
        default: begin funct = 6'b101010; exp[8:4] = 5'b00111; end
      endcase
      op = 6'b000000;
      pulse_reset();
      for (int c = 1; c < 4; c++) tick();
      checks++;
      if (w_o1 !== exp) begin errors++; $display("FAIL exec_funct%0d got=%h exp=%h", i, w_o1, exp); end
    end
  endtask

  task automatic test_lw_lat3();
    logic [20:0] exp;
    op = 6'b100011;
    pulse_reset();
    for (int c = 1; c <= 11; c++) begin
      case (c)
        1, 2: exp = E_FETCH_NO; 3: exp = E_FETCH_IR; 4: exp = E_INC; 5: exp = E_DECODE;
        6: exp = E_MEMADR; 7, 8, 9: exp = E_MEMRD; 10: exp = E_MEMWB; default: exp = E_FETCH_NO;
      endcase
      checks++;
      if (w_o3 !== exp) begin errors++; $display("FAIL lw_lat3 cyc%0d got=%h exp=%h", c, w_o3, exp); end
      tick();
    end
  endtask

  task automatic test_sw();
    logic [20:0] exp;
    op = 6'b101011;
    pulse_reset();
    for (int c = 1; c <= 6; c++) begin
      case (c)
        1: exp = E_FETCH_IR; 2: exp = E_INC; 3: exp = E_DECODE;
        4: exp = E_MEMADR; 5: exp = E_MEMWR; default: exp = E_FETCH_IR;
      endcase
      checks++;
      if (w_o1 !== exp) begin errors++; $display("FAIL sw cyc%0d got=%h exp=%h", c, w_o1, exp); end
      tick();
    end
  endtask

  task automatic test_beq();
    logic [20:0] exp;
    op = 6'b000100;
    for (int z = 0; z < 2; z++) begin
      zero = (z == 0);
      pulse_reset();
      for (int c = 1; c <= 6; c++) begin
        case (c)
          1: exp = E_FETCH_IR; 2: exp = E_INC; 3: exp = E_DECODE;
          4: exp = E_BRTGT; 5: exp = E_BRCMP; default: exp = E_FETCH_IR;
        endcase
        checks++;
        if (w_o1 !== exp) begin errors++; $display("FAIL beq_zero%0d cyc%0d got=%h exp=%h", zero, c, w_o1, exp); end
        tick();
      end
    end
    zero = 1'b0;
  endtask

  task automatic test_addi_jump();
    logic [20:0] exp;
    op = 6'b001000;
    pulse_reset();
    for (int c = 1; c <= 6; c++) begin
      case (c)
        1: exp = E_FETCH_IR; 2: exp = E_INC; 3: exp = E_DECODE;
        4: exp = E_MEMADR; 5: exp = E_ADDIWB; default: exp = E_FETCH_IR;
      endcase
      checks++;
      if (w_o1 !== exp) begin errors++; $display("FAIL addi cyc%0d got=%h exp=%h", c, w_o1, exp); end
      tick();
    end
    op = 6'b000010;
    pulse_reset();
    for (int c = 1; c <= 5; c++) begin
      case (c)
        1: exp = E_FETCH_IR; 2: exp = E_INC; 3: exp = E_DECODE;
        4: exp = E_JUMP; default: exp = E_FETCH_IR;
      endcase
      checks++;
      if (w_o1 !== exp) begin errors++; $display("FAIL jump cyc%0d got=%h exp=%h", c, w_o1, exp); end
      tick();
    end
  endtask

  task automatic test_illegal();
    logic [20:0] exp;
    op = 6'b111111;
    pulse_reset();
    for (int c = 1; c <= 6; c++) begin
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
      case (c)
        1: exp = E_FETCH_IR; 2: exp = E_INC; 3: exp = E_DECODE; default: exp = E_TRAP;
      endcase
`else
      case (c)
        1, 4: exp = E_FETCH_IR; 2, 5: exp = E_INC; default: exp = E_DECODE;
      endcase
`endif
      checks++;
      if (w_o1 !== exp) begin errors++; $display("FAIL illegal_op cyc%0d got=%h exp=%h", c, w_o1, exp); end
      tick();
    end
    op = 6'b000000; funct = 6'b000001;
    pulse_reset();
    for (int c = 1; c < 5; c++) tick();
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
    exp = E_TRAP;
`else
    exp = E_FETCH_IR;
`endif
    checks++;
    if (w_o1 !== exp) begin errors++; $display("FAIL illegal_funct got=%h exp=%h", w_o1, exp); end
    funct = 6'b100000;
  endtask

  task automatic test_reset_mid();
    logic [20:0] exp;
    op = 6'b100011;
    pulse_reset();
    for (int c = 1; c < 8; c++) tick();
    checks++;
    if (w_o3 !== E_MEMRD) begin errors++; $display("FAIL midrst_pre got=%h exp=%h", w_o3, E_MEMRD); end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (w_o3 !== E_FETCH_NO) begin errors++; $display("FAIL midrst_abort got=%h exp=%h", w_o3, E_FETCH_NO); end
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    for (int c = 1; c <= 4; c++) begin
      case (c)
        1, 2: exp = E_FETCH_NO; 3: exp = E_FETCH_IR; default: exp = E_INC;
      endcase
      checks++;
      if (w_o3 !== exp) begin errors++; $display("FAIL midrst_refetch cyc%0d got=%h exp=%h", c, w_o3, exp); end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_alu_functs();
    test_lw_lat3();
    test_sw();
    test_beq();
    test_addi_jump();
    test_illegal();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
